// File: rtl/dwt_coef_packer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dwt_coef_packer_if : DWT coefficient input / word stream output bus |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dwt_coef_packer_if #(
  parameter int pWIDTH = 16,
  parameter int pDEPTH = 8
);
  logic                      iclk_ena;
  logic                      iena;
  logic [2*pWIDTH-1:0]       idatH;
  logic [2*pWIDTH-1:0]       idatL;
  logic                      irdy;
  logic                      oval;
  logic [pWIDTH-1:0]         odat;
  logic                      osel;
  logic [$clog2(pDEPTH):0]   ofill;
  logic                      osat;
  logic                      oovf;

  modport master (
    output iclk_ena, iena, idatH, idatL, irdy,
    input  oval, odat, osel, ofill, osat, oovf
  );

  modport slave (
    input  iclk_ena, iena, idatH, idatL, irdy,
    output oval, odat, osel, ofill, osat, oovf
  );
endinterface
`default_nettype wire

// File: rtl/dwt_coef_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dwt_coef_packer : requantize H/L pairs, buffer, stream L then H    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dwt_coef_packer #(
  parameter int pWIDTH = 16,
  parameter int pSHIFT = 15,
  parameter int pDEPTH = 8
) (
  input  logic             iclk,
  input  logic             irst_n,
  dwt_coef_packer_if.slave bus
);
  localparam int AW = $clog2(pDEPTH);
  localparam int TW = 2*pWIDTH + 1;
  localparam logic signed [TW-1:0] HALF = TW'(1) << (pSHIFT-1);
  localparam logic signed [TW-1:0] MAXV = TW'((1 << (pWIDTH-1)) - 1);
  localparam logic signed [TW-1:0] MINV = ~MAXV;
  localparam logic [AW:0]          FULL = (AW+1)'(pDEPTH);

  typedef enum logic [1:0] {IDLE, SEND_L, SEND_H} state_t;

  // Returns {saturated, value}; one extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [pWIDTH:0] requant(input logic [2*pWIDTH-1:0] x);
    logic signed [TW-1:0] t;
    t = $signed({x[2*pWIDTH-1], x}) + HALF;
    t = t >>> pSHIFT;
    if (t > MAXV)      return {1'b1, MAXV[pWIDTH-1:0]};
    else if (t < MINV) return {1'b1, MINV[pWIDTH-1:0]};
    else               return {1'b0, t[pWIDTH-1:0]};
  endfunction

  logic [pWIDTH:0]     rq_l, rq_h;
  logic                s1_vld;
  logic [pWIDTH-1:0]   s1_l, s1_h;
  logic [1:0]          s1_sat;
  logic [2*pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         fill;
  logic                full, push, pop, take;
  logic [2*pWIDTH-1:0] rd_word;
  state_t              state;
  logic                out_vld, out_sel, sat_pulse, ovf_flag;
  logic [pWIDTH-1:0]   out_dat, hold_h;

  assign rq_l = requant(bus.idatL);
  assign rq_h = requant(bus.idatH);
  assign take = bus.iclk_ena && bus.iena;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_vld <= 1'b0;
      s1_l   <= '0;
      s1_h   <= '0;
      s1_sat <= '0;
    end else begin
      s1_vld <= take;
      if (take) begin
        s1_l   <= rq_l[pWIDTH-1:0];
        s1_h   <= rq_h[pWIDTH-1:0];
        s1_sat <= {rq_h[pWIDTH], rq_l[pWIDTH]};
      end
    end
  end

  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign full    = (fill == FULL);
  assign push    = s1_vld && !full;
  assign pop     = (fill != '0) && ((state == IDLE) || ((state == SEND_H) && bus.irdy));
  assign rd_word = mem[rd_ptr];

  always_ff @(posedge iclk) begin
    if (push) mem[wr_ptr] <= {s1_h, s1_l};
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      sat_pulse <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
      sat_pulse <= push && (|s1_sat);
      if (s1_vld && full) ovf_flag <= 1'b1;
    end
  end

  // H of the popped pair waits in hold_h while L is on the bus.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state   <= IDLE;
      out_vld <= 1'b0;
      out_dat <= '0;
      out_sel <= 1'b0;
      hold_h  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            out_dat <= rd_word[pWIDTH-1:0];
            hold_h  <= rd_word[2*pWIDTH-1:pWIDTH];
            out_sel <= 1'b0;
            out_vld <= 1'b1;
            state   <= SEND_L;
          end
        end
        SEND_L: begin
          if (bus.irdy) begin
            out_dat <= hold_h;
            out_sel <= 1'b1;
            state   <= SEND_H;
          end
        end
        SEND_H: begin
          if (bus.irdy) begin
            if (pop) begin
              out_dat <= rd_word[pWIDTH-1:0];
              hold_h  <= rd_word[2*pWIDTH-1:pWIDTH];
              out_sel <= 1'b0;
              state   <= SEND_L;
            end else begin
              out_vld <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          out_vld <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.oval  = out_vld;
  assign bus.odat  = out_dat;
  assign bus.osel  = out_sel;
  assign bus.ofill = fill;
  assign bus.osat  = sat_pulse;
  assign bus.oovf  = ovf_flag;
endmodule
`default_nettype wire

// File: tb/tb_dwt_coef_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dwt_coef_packer : randomized bench with queue reference model   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dwt_coef_packer;
  localparam int W = 16;

  typedef struct packed {
    logic          sel;
    logic [W-1:0]  dat;
  } word_t;

  logic  clk;
  logic  rst_n;
  int    checks;
  int    failures;
  word_t exp_q[$];
  int    sat_cnt;
  int    max_fill;
  bit    prev_stall;
  logic [W-1:0] prev_dat;
  logic  prev_sel;

  dwt_coef_packer_if #(.pWIDTH(W), .pDEPTH(8)) bus ();

  dwt_coef_packer #(.pWIDTH(W), .pSHIFT(15), .pDEPTH(8)) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference requantizer: round half up at 2^15, floor, clamp to 16-bit signed.
  function automatic logic [W-1:0] ref_rq(input logic [31:0] x, output bit sat);
    longint t;
    t = longint'($signed(x)) + (longint'(1) << 14);
    t = t >>> 15;
    sat = 1'b0;
    if (t > 32767)  begin t = 32767;  sat = 1'b1; end
    if (t < -32768) begin t = -32768; sat = 1'b1; end
    return t[W-1:0];
  endfunction

  function automatic void model_push(input logic [31:0] l, input logic [31:0] h);
    bit s;
    exp_q.push_back('{sel: 1'b0, dat: ref_rq(l, s)});
    exp_q.push_back('{sel: 1'b1, dat: ref_rq(h, s)});
  endfunction

  // Called at #1 after a rising edge; leaves the same phase.
  task automatic send_pair(input logic [31:0] l, input logic [31:0] h, input bit model);
    bus.iclk_ena = 1'b1;
    bus.iena     = 1'b1;
    bus.idatL    = l;
    bus.idatH    = h;
    if (model) model_push(l, h);
    @(posedge clk); #1;
    bus.iclk_ena = 1'b0;
    bus.iena     = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.irdy = 1'b1;
    while ((exp_q.size() != 0 || bus.oval) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain_left"}, exp_q.size(), 0);
  endtask

  // Monitor: samples on the falling edge, i.e. what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.osat) sat_cnt++;
      if (int'(bus.ofill) > max_fill) max_fill = int'(bus.ofill);
      if (prev_stall) begin
        chk("hold_oval", bus.oval, 1);
        chk("hold_odat", bus.odat, prev_dat);
        chk("hold_osel", bus.osel, prev_sel);
      end
      if (bus.oval && bus.irdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("odat", bus.odat, e.dat);
          chk("osel", bus.osel, e.sel);
        end
      end
      prev_stall = bus.oval && !bus.irdy;
      prev_dat   = bus.odat;
      prev_sel   = bus.osel;
    end
  end

  initial begin
    logic [31:0] l, h;
    logic [W-1:0] d0;
    bit s0;
    checks = 0; failures = 0; sat_cnt = 0; max_fill = 0;
    prev_stall = 1'b0; prev_dat = '0; prev_sel = 1'b0;
    rst_n = 1'b0;
    bus.iclk_ena = 1'b0; bus.iena = 1'b0; bus.irdy = 1'b0;
    bus.idatL = '0; bus.idatH = '0;
    cycles(3);
    chk("rst_oval",  bus.oval, 0);
    chk("rst_odat",  bus.odat, 0);
    chk("rst_osel",  bus.osel, 0);
    chk("rst_ofill", bus.ofill, 0);
    chk("rst_osat",  bus.osat, 0);
    chk("rst_oovf",  bus.oovf, 0);
    rst_n = 1'b1;
    cycles(2);

    // Rounding and latency
    bus.irdy = 1'b1;
    sat_cnt = 0;
    send_pair(32'h0001_0000, 32'h0000_4000, 1'b1);
    chk("lat_n1", bus.oval, 0);
    cycles(1);
    chk("lat_n2", bus.oval, 0);
    cycles(1);
    chk("lat_n3", bus.oval, 1);
    send_pair(32'hFFFF_C000, 32'hFFFF_BFFF, 1'b1);
    drain("round");
    chk("round_nosat", sat_cnt, 0);

    // Saturation
    sat_cnt = 0;
    send_pair(32'hC000_0000, 32'h4000_0000, 1'b1);
    drain("sat");
    chk("sat_pulse", sat_cnt, 1);

    // Backpressure
    bus.irdy = 1'b0;
    l = $urandom; h = $urandom;
    send_pair(l, h, 1'b1);
    for (int i = 0; i < 20 && !bus.oval; i++) cycles(1);
    chk("bp_oval", bus.oval, 1);
    d0 = ref_rq(l, s0);
    cycles(20);
    chk("bp_odat", bus.odat, d0);
    chk("bp_osel", bus.osel, 0);
    drain("bp");

    // Streaming ramp at one pair per 16 cycles
    max_fill = 0;
    for (int k = 0; k < 100; k++) begin
      send_pair(32'(k) << 15, 32'(-k) << 15, 1'b1);
      cycles(15);
    end
    drain("stream");
    chk("stream_maxfill", max_fill <= 1, 1);
    chk("stream_oovf", bus.oovf, 0);

    // Randomized: gated enables, random backpressure, mixed magnitudes
    for (int slot = 0; slot < 150; slot++) begin
      for (int c = 0; c < 8; c++) begin
        bus.iclk_ena = (c == 0);
        bus.iena     = 1'($urandom);
        l = $urandom; h = $urandom;
        case ($urandom % 3)
          0: begin l = 32'($signed(l) >>> 10); h = 32'($signed(h) >>> 10); end
          1: begin l = 32'($signed(l) >>> 16); h = 32'($signed(h) >>> 1);  end
          default: ;
        endcase
        bus.idatL = l;
        bus.idatH = h;
        bus.irdy  = ($urandom % 4) != 0;
        if (bus.iclk_ena && bus.iena) model_push(l, h);
        @(posedge clk); #1;
      end
    end
    bus.iclk_ena = 1'b0; bus.iena = 1'b0;
    drain("rand");
    chk("rand_oovf", bus.oovf, 0);

    // Overflow: 9 pairs fit (1 in output regs + 8 buffered), 10th is dropped
    bus.irdy = 1'b0;
    for (int k = 0; k < 9; k++) send_pair(32'(k + 1) << 15, 32'(-(k + 1)) << 15, 1'b1);
    cycles(3);
    chk("ovf_oval",  bus.oval, 1);
    chk("ovf_fill8", bus.ofill, 8);
    chk("ovf_pre",   bus.oovf, 0);
    send_pair(32'h1234_5678, 32'h0765_4321, 1'b0);
    cycles(2);
    chk("ovf_set",   bus.oovf, 1);
    chk("ovf_fill",  bus.ofill, 8);
    drain("ovf");
    chk("ovf_sticky", bus.oovf, 1);

    // Reset in SEND_H with three pairs buffered
    bus.irdy = 1'b0;
    for (int k = 0; k < 4; k++) send_pair($urandom, $urandom, 1'b1);
    cycles(4);
    bus.irdy = 1'b1;
    cycles(1);
    bus.irdy = 1'b0;
    chk("mid_osel",  bus.osel, 1);
    chk("mid_fill",  bus.ofill, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_oval",  bus.oval, 0);
    chk("mid_fill0", bus.ofill, 0);
    chk("mid_oovf",  bus.oovf, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    bus.irdy = 1'b1;
    send_pair(32'h0003_0000, 32'hFFFD_0000, 1'b1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
